// File: rtl/alu_operand_issue_pkg.sv
// alu_operand_issue_pkg: shared widths and timing constants for the operand-issue stage
package alu_operand_issue_pkg;
    localparam int W    = 32;
    localparam int NREG = 8;
    localparam int AW   = 3;
    localparam int OPW  = 3;
    localparam int LAT  = 2;
endpackage

// File: rtl/alu_regfile.sv
// alu_regfile: NREG x W register file, writeback-over-load priority, r0 reads as zero
module alu_regfile
    import alu_operand_issue_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    input  logic          wb_en,
    input  logic [AW-1:0] wb_addr,
    input  logic [W-1:0]  wb_data,
    input  logic          ld_en,
    input  logic [AW-1:0] ld_addr,
    input  logic [W-1:0]  ld_data,
    input  logic [AW-1:0] ra_addr,
    input  logic [AW-1:0] rb_addr,
    input  logic [AW-1:0] dbg_addr,
    output logic [W-1:0]  ra_data,
    output logic [W-1:0]  rb_data,
    output logic [W-1:0]  dbg_data
);
    logic [W-1:0] mem [NREG];

    // per-entry update; entry 0 is never written so it stays zero after reset
    always_ff @(posedge clk or posedge rst)
        if (rst)
            for (int i = 0; i < NREG; i++) mem[i] <= '0;
        else
            for (int i = 1; i < NREG; i++)
                if (wb_en && wb_addr == AW'(i)) mem[i] <= wb_data;
                else if (ld_en && ld_addr == AW'(i)) mem[i] <= ld_data;

    assign ra_data  = ra_addr  == '0 ? '0 : mem[ra_addr];
    assign rb_data  = rb_addr  == '0 ? '0 : mem[rb_addr];
    assign dbg_data = dbg_addr == '0 ? '0 : mem[dbg_addr];
endmodule

// File: rtl/alu_operand_issue.sv
// alu_operand_issue: issues operands to the ALU, tracks in-flight results and writes them back
module alu_operand_issue
    import alu_operand_issue_pkg::*;
(
    input  logic           clk,
    input  logic           rst,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [OPW-1:0] in_op,
    input  logic [AW-1:0]  in_rd,
    input  logic [AW-1:0]  in_rs,
    input  logic [AW-1:0]  in_rt,
    input  logic           ld_en,
    input  logic [AW-1:0]  ld_addr,
    input  logic [W-1:0]   ld_data,
    output logic [W-1:0]   R2,
    output logic [W-1:0]   R3,
    output logic [OPW-1:0] ALUOp,
    input  logic [W-1:0]   R0,
    output logic           wb_valid,
    output logic [AW-1:0]  wb_addr,
    input  logic [AW-1:0]  dbg_addr,
    output logic [W-1:0]   dbg_data
);
    logic [LAT-1:0] sv;
    logic [AW-1:0]  srd [LAT];
    logic [W-1:0]   ra, rb;
    logic           hazard, accept;

    assign hazard   = sv[0] && srd[0] != '0 && (srd[0] == in_rs || srd[0] == in_rt);
    assign in_ready = !rst && !ld_en && !hazard;
    assign accept   = in_valid && in_ready;
    assign wb_valid = sv[LAT-1] && srd[LAT-1] != '0;
    assign wb_addr  = srd[LAT-1];

    alu_regfile u_rf (
        .clk(clk), .rst(rst),
        .wb_en(wb_valid), .wb_addr(wb_addr), .wb_data(R0),
        .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data),
        .ra_addr(in_rs), .rb_addr(in_rt), .dbg_addr(dbg_addr),
        .ra_data(ra), .rb_data(rb), .dbg_data(dbg_data)
    );

    // capture operands on accept (R0 bypass for same-edge writeback) and advance the occupancy pipe
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            R2    <= '0;
            R3    <= '0;
            ALUOp <= '0;
            sv    <= '0;
            for (int i = 0; i < LAT; i++) srd[i] <= '0;
        end else begin
            if (accept) begin
                R2    <= wb_valid && wb_addr == in_rs ? R0 : ra;
                R3    <= wb_valid && wb_addr == in_rt ? R0 : rb;
                ALUOp <= in_op;
            end
            sv     <= {sv[LAT-2:0], accept};
            srd[0] <= in_rd;
            for (int i = 1; i < LAT; i++) srd[i] <= srd[i-1];
        end
endmodule

// File: tb/tb_alu_operand_issue.sv
// tb_alu_operand_issue: directed bench with an adder stub and writeback scoreboard
`timescale 1ns/1ps
module tb_alu_operand_issue;
    logic        clk = 0, rst = 1;
    logic        in_valid = 0, in_ready;
    logic [2:0]  in_op = 0, in_rd = 0, in_rs = 0, in_rt = 0;
    logic        ld_en = 0;
    logic [2:0]  ld_addr = 0, dbg_addr = 0, wb_addr;
    logic [31:0] ld_data = 0, R2, R3, R0, dbg_data;
    logic [2:0]  ALUOp;
    logic        wb_valid;

    int          nvec = 0, nerr = 0, run = 0, max_run = 0, st;
    logic [31:0] m [8];
    logic [34:0] q [$];
    logic [34:0] e;

    alu_operand_issue dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_op(in_op), .in_rd(in_rd), .in_rs(in_rs), .in_rt(in_rt),
        .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data),
        .R2(R2), .R3(R3), .ALUOp(ALUOp), .R0(R0),
        .wb_valid(wb_valid), .wb_addr(wb_addr),
        .dbg_addr(dbg_addr), .dbg_data(dbg_data)
    );

    always #50 clk = ~clk;

    // downstream stub: registered sum regardless of ALUOp
    always @(posedge clk or posedge rst)
        if (rst) R0 <= '0;
        else R0 <= R2 + R3;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        nvec++;
        assert (got === exp) else begin
            nerr++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // scoreboard: every writeback must match the oldest outstanding expectation
    always @(negedge clk) begin
        if (rst) run = 0;
        else if (wb_valid) begin
            run++;
            if (run > max_run) max_run = run;
            nvec++;
            assert (q.size() != 0) else begin
                nerr++;
                $error("FAIL wb_unexpected observed=%0d expected=none", wb_addr);
            end
            if (q.size() != 0) begin
                e = q.pop_front();
                chk("wb", {wb_addr, R0}, {29'd0, e});
            end
        end else run = 0;
    end

    task automatic dbgchk(input logic [2:0] a);
        dbg_addr = a;
        #1;
        chk($sformatf("dbg_r%0d", a), dbg_data, m[a]);
    endtask

    task automatic load(input logic [2:0] a, input logic [31:0] d);
        ld_en = 1; ld_addr = a; ld_data = d;
        #1;
        chk("ld_blocks_ready", in_ready, 0);
        @(posedge clk); #1;
        ld_en = 0;
        if (a != 0) m[a] = d;
    endtask

    task automatic issue(input logic [2:0] op, rd, rs, rt, output int stalls);
        logic [31:0] a, b;
        in_valid = 1; in_op = op; in_rd = rd; in_rs = rs; in_rt = rt;
        stalls = 0;
        #1;
        while (!in_ready && stalls < 8) begin
            @(posedge clk); #2;
            stalls++;
        end
        chk("issue_ready", in_ready, 1);
        a = m[rs]; b = m[rt];
        @(posedge clk); #1;
        in_valid = 0;
        chk("R2", R2, a);
        chk("R3", R3, b);
        chk("ALUOp", ALUOp, op);
        if (rd != 0) begin
            m[rd] = a + b;
            q.push_back({rd, a + b});
        end
    endtask

    task automatic drain();
        repeat (4) @(posedge clk);
        #1;
    endtask

    initial begin
        for (int i = 0; i < 8; i++) m[i] = 0;
        repeat (2) @(posedge clk);
        #1;
        for (int i = 0; i < 8; i++) dbgchk(3'(i));
        chk("rst_R2", R2, 0);
        chk("rst_R3", R3, 0);
        chk("rst_ALUOp", ALUOp, 0);
        chk("rst_ready", in_ready, 0);
        chk("rst_wb", wb_valid, 0);
        rst = 0;
        @(posedge clk); #1;

        load(1, 5);
        load(2, 7);
        load(0, 9);
        dbgchk(1); dbgchk(2); dbgchk(0);

        issue(3'b010, 3, 1, 2, st);
        chk("indep_stall", st, 0);
        @(posedge clk); #1;
        chk("wb_valid_e1", wb_valid, 1);
        chk("wb_addr_e1", wb_addr, 3);
        @(posedge clk); #1;
        dbgchk(3);

        issue(3'b010, 4, 1, 2, st);
        issue(3'b010, 5, 4, 1, st);
        chk("hazard_bubble", st, 1);
        chk("bypass_R2", R2, 12);
        drain();
        dbgchk(4); dbgchk(5);
        chk("r5_value", dbg_data, 17);

        issue(3'b001, 0, 1, 2, st);
        issue(3'b001, 7, 0, 1, st);
        chk("r0_no_stall", st, 0);
        drain();
        dbgchk(0); dbgchk(7);

        max_run = 0;
        issue(3'b000, 3, 1, 2, st); chk("b2b_stall0", st, 0);
        issue(3'b011, 4, 1, 1, st); chk("b2b_stall1", st, 0);
        issue(3'b100, 5, 2, 2, st); chk("b2b_stall2", st, 0);
        issue(3'b101, 6, 2, 1, st); chk("b2b_stall3", st, 0);
        drain();
        chk("b2b_wb_run", max_run, 4);
        for (int i = 3; i < 7; i++) dbgchk(3'(i));

        issue(3'b010, 3, 1, 1, st);
        ld_en = 1; ld_addr = 3; ld_data = 99;
        #1;
        chk("collide_ready", in_ready, 0);
        @(posedge clk); #1;
        ld_en = 0;
        drain();
        dbgchk(3);
        chk("queue_drained", q.size(), 0);

        issue(3'b010, 6, 1, 2, st);
        rst = 1;
        q.delete();
        for (int i = 0; i < 8; i++) m[i] = 0;
        #1;
        chk("midrst_wb", wb_valid, 0);
        repeat (2) @(posedge clk); #1;
        rst = 0;
        drain();
        for (int i = 0; i < 8; i++) dbgchk(3'(i));

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
